spi_lcd_frame_streamer: RTL and testbench
=========================================

Name: spi_lcd_frame_streamer

Overview:
Parametrised successor to the single-shot Nokia 5110 bring-up FSM. It runs the PCD8544-class reset and init sequence and then idles. On request it streams a full frame from an external framebuffer read port. It also supports runtime contrast updates. It sits between the pixel/framebuffer logic and the existing SPI_Master (instantiated inside, TX-only, MISO tied 0).

Parameters:
- CLKS_PER_HALF_BIT, 25, passed to SPI_Master; SPI clock = i_Clk / (2*value).
- RST_HOLD_CLKS, 4096, cycles o_LCD_RST held low after reset (min 1).
- COLS, 84, display columns.
- PAGES, 6, 8-row pages; FB_BYTES = COLS*PAGES; address width FB_AW = $clog2(FB_BYTES).
- CONTRAST, 7'h31, Vop at init.
- BIAS, 3'd4, bias system value.
- TEMP_COEF, 2'd0, temperature coefficient.

Ports:
- i_Clk  in  1  clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Refresh  in  1  single-cycle frame request
- i_Contrast_Wr  in  1  single-cycle contrast update strobe
- i_Contrast  in  7  new Vop, sampled when i_Contrast_Wr=1
- o_Fb_Addr  out  FB_AW  framebuffer byte address
- o_Fb_Rd  out  1  read strobe; data valid on i_Fb_Data the following cycle
- i_Fb_Data  in  8  framebuffer byte
- o_Busy  out  1  high in every state except IDLE
- o_Frame_Done  out  1  one-cycle pulse after last frame byte completes
- o_SPI_Clk, o_SPI_MOSI  out  1  SPI mode 0
- o_LCD_DC, o_LCD_RST, o_LCD_CE  out  1  LCD control

Behaviour:
- Reset values: o_LCD_RST=0, o_LCD_CE=1, o_LCD_DC=0, o_Busy=1, o_Frame_Done=0, o_Fb_Addr=0, o_Fb_Rd=0, pending flags=0, state=RST_HOLD. Reset mid-operation aborts immediately; no partial byte is resumed.
- States and transitions:
  - RST_HOLD: counts RST_HOLD_CLKS cycles, then goes to RST_REL.
  - RST_REL: sets RST=1 for one cycle, then goes to INIT.
  - INIT: CE=0, DC=0; sends 0x21, 0x80|CONTRAST, 0x04|TEMP_COEF, 0x10|BIAS, 0x20, 0x0C in order; then goes to IDLE.
  - IDLE: CE=1, o_Busy=0.
  - SETXY: CE=0, DC=0; sends 0x80, 0x40.
  - FETCH: o_Fb_Rd=1 with o_Fb_Addr=idx.
  - SEND: captures i_Fb_Data, DC=1, sends the byte; idx+1; returns to FETCH until idx==FB_BYTES-1 has completed, then goes to DONE.
  - DONE: o_Frame_Done=1 for one cycle, CE=1, then goes to IDLE.
  - CONTRAST: CE=0, DC=0; sends 0x21, 0x80|latched Vop, 0x20; then goes to IDLE.
- Byte handshake: assert TX_DV for exactly one cycle, only while TX_Ready=1. Change DC no later than the TX_DV cycle. Ignore TX_Ready for the one cycle after TX_DV, then wait for TX_Ready=1 before the next byte.
- Request latching:
  - i_Refresh and i_Contrast_Wr set sticky pending flags in any state except RST_HOLD/RST_REL/INIT; requests arriving in those states are dropped.
  - Multiple refreshes while pending collapse to one. A second contrast write overwrites the latched value.
- IDLE priority: contrast pending > refresh pending. Flags clear on leaving IDLE for the serviced operation.
- Simultaneous i_Refresh and i_Contrast_Wr in IDLE: CONTRAST runs first, then the frame.
- idx wraps to 0 at frame start; no address beyond FB_BYTES-1 is ever issued.

Optional Feature:
LCD_AUTO_REFRESH_EN
- Defined: adds parameter REFRESH_PERIOD_CLKS (default 2_000_000). A free-running counter, reset to 0 and restarted on every DONE, sets the refresh pending flag at terminal count.
- Undefined: frames are sent only on i_Refresh; the counter and parameter do not exist.

Decomposition:
- Shared package lcd_pcd8544_pkg holds:
  - Command constants: CMD_FUNC_EXT=0x21, CMD_FUNC_BASIC=0x20, CMD_VOP=0x80, CMD_TEMP=0x04, CMD_BIAS=0x10, CMD_DISP_NORMAL=0x0C, CMD_SET_X=0x80, CMD_SET_Y=0x40.
  - State enum.
- Sub-module lcd_byte_sender wraps SPI_Master. It provides a byte/DC/valid/done interface and implements the DV/Ready guard rule.

Test Plan:
- Reset release, RST_HOLD_CLKS=16, CLKS_PER_HALF_BIT=2 -> o_LCD_RST low exactly 16 cycles; then MOSI carries 0x21,0xB1,0x04,0x14,0x20,0x0C with DC=0 and CE=0; o_Busy falls after the last byte.
- i_Refresh in IDLE with framebuffer byte n = n[7:0] -> 0x80,0x40 at DC=0, then 504 bytes at DC=1 with values 0x00..0xF7 and addresses 0..503 each read once; o_Frame_Done pulses once; CE=1 after.
- Three i_Refresh pulses mid-frame -> exactly one additional frame follows.
- i_Contrast=0x45 together with i_Refresh in IDLE -> 0x21,0xC5,0x20 sent first, then the full frame.
- i_Rst_L asserted at byte 200 of a frame -> all outputs return to reset values within the same cycle; the full init sequence repeats; no o_Frame_Done pulse.
- With LCD_AUTO_REFRESH_EN and REFRESH_PERIOD_CLKS=5000 -> a frame starts with no i_Refresh after DONE+5000 cycles.

Source files
------------

// File: rtl/lcd_pcd8544_pkg.sv
// PCD8544 command bytes and the state encodings shared by the LCD frame streamer.
package lcd_pcd8544_pkg;

  localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
  localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
  localparam logic [7:0] CMD_VOP         = 8'h80;
  localparam logic [7:0] CMD_TEMP        = 8'h04;
  localparam logic [7:0] CMD_BIAS        = 8'h10;
  localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
  localparam logic [7:0] CMD_SET_X       = 8'h80;
  localparam logic [7:0] CMD_SET_Y       = 8'h40;

  typedef enum logic [3:0] {
    ST_RST_HOLD,
    ST_RST_REL,
    ST_INIT,
    ST_IDLE,
    ST_SETXY,
    ST_FETCH,
    ST_SEND,
    ST_DONE,
    ST_CONTRAST
  } lcd_state_e;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_GUARD,
    SND_WAIT
  } snd_state_e;

endpackage

// File: rtl/SPI_Master.sv
// Mode-0 SPI master: MSB first, MOSI changes on falling SCLK and is sampled on rising SCLK.
// A byte takes 16*CLKS_PER_HALF_BIT cycles; o_TX_Ready is low while it is on the wire.
module SPI_Master #(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Rst_L,
  input  logic       i_Clk,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam int CW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;

  logic [CW-1:0] half_cnt_q;
  logic [4:0]    edge_cnt_q;
  logic          sclk_q;
  logic [7:0]    tx_sr_q;
  logic [7:0]    rx_sr_q;
  logic          rx_dv_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      half_cnt_q <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      if (edge_cnt_q == 5'd0) begin
        if (i_TX_DV) begin
          tx_sr_q    <= i_TX_Byte;
          edge_cnt_q <= 5'd16;
          half_cnt_q <= '0;
        end
      end else if (half_cnt_q == CW'(CLKS_PER_HALF_BIT - 1)) begin
        half_cnt_q <= '0;
        sclk_q     <= ~sclk_q;
        edge_cnt_q <= edge_cnt_q - 5'd1;
        if (sclk_q) tx_sr_q <= {tx_sr_q[6:0], 1'b0};
        else        rx_sr_q <= {rx_sr_q[6:0], i_SPI_MISO};
        if (edge_cnt_q == 5'd1) rx_dv_q <= 1'b1;
      end else begin
        half_cnt_q <= half_cnt_q + 1'b1;
      end
    end
  end

  assign o_TX_Ready = (edge_cnt_q == 5'd0);
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Byte  = rx_sr_q;
  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_MOSI = tx_sr_q[7];

endmodule

// File: rtl/lcd_byte_sender.sv
// Byte/DC/valid/done front end for SPI_Master; one SPI byte per accepted request, done pulses when it has left the wire.
// DC switches in the accept cycle and holds until the next accept; ready is blanked for the cycle after TX_DV.
module lcd_byte_sender
  import lcd_pcd8544_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 25
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_dc_i,
  input  logic       tx_vld_i,
  output logic       tx_rdy_o,
  output logic       tx_done_o,
  output logic       dc_o,
  output logic       spi_clk_o,
  output logic       spi_mosi_o
);

  snd_state_e state_q, state_d;
  logic       dc_q, dc_d;
  logic       spi_rdy;
  logic       spi_dv;
  logic       unused_rx_dv;
  logic [7:0] unused_rx_byte;

  SPI_Master #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_spi (
    .i_Rst_L   (i_Rst_L),
    .i_Clk     (i_Clk),
    .i_TX_Byte (tx_dat_i),
    .i_TX_DV   (spi_dv),
    .o_TX_Ready(spi_rdy),
    .o_RX_DV   (unused_rx_dv),
    .o_RX_Byte (unused_rx_byte),
    .o_SPI_Clk (spi_clk_o),
    .i_SPI_MISO(1'b0),
    .o_SPI_MOSI(spi_mosi_o)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= SND_IDLE;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dc_d      = dc_q;
    spi_dv    = 1'b0;
    tx_rdy_o  = 1'b0;
    tx_done_o = 1'b0;
    case (state_q)
      SND_IDLE: begin
        tx_rdy_o = spi_rdy;
        if (tx_vld_i && spi_rdy) begin
          spi_dv  = 1'b1;
          dc_d    = tx_dc_i;
          state_d = SND_GUARD;
        end
      end
      // SPI_Master may still report ready in the cycle right after TX_DV.
      SND_GUARD: state_d = SND_WAIT;
      SND_WAIT: begin
        if (spi_rdy) begin
          tx_done_o = 1'b1;
          state_d   = SND_IDLE;
        end
      end
      default: state_d = SND_IDLE;
    endcase
  end

  assign dc_o = dc_d;

endmodule

// File: rtl/spi_lcd_frame_streamer.sv
// PCD8544 reset/init, full-frame streaming from a framebuffer read port and runtime contrast updates over SPI.
// Optional LCD_AUTO_REFRESH_EN: a free-running counter requests a frame every REFRESH_PERIOD_CLKS cycles.
module spi_lcd_frame_streamer
  import lcd_pcd8544_pkg::*;
#(
  parameter int         CLKS_PER_HALF_BIT   = 25,
  parameter int         RST_HOLD_CLKS       = 4096,
  parameter int         COLS                = 84,
  parameter int         PAGES               = 6,
  parameter logic [6:0] CONTRAST            = 7'h31,
  parameter logic [2:0] BIAS                = 3'd4,
  parameter logic [1:0] TEMP_COEF           = 2'd0,
`ifdef LCD_AUTO_REFRESH_EN
  parameter int         REFRESH_PERIOD_CLKS = 2_000_000,
`endif
  localparam int        FB_BYTES            = COLS * PAGES,
  localparam int        FB_AW               = $clog2(FB_BYTES)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Refresh,
  input  logic             i_Contrast_Wr,
  input  logic [6:0]       i_Contrast,
  output logic [FB_AW-1:0] o_Fb_Addr,
  output logic             o_Fb_Rd,
  input  logic [7:0]       i_Fb_Data,
  output logic             o_Busy,
  output logic             o_Frame_Done,
  output logic             o_SPI_Clk,
  output logic             o_SPI_MOSI,
  output logic             o_LCD_DC,
  output logic             o_LCD_RST,
  output logic             o_LCD_CE
);

  localparam int HW = $clog2(RST_HOLD_CLKS + 1);

  lcd_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [2:0]       seq_q, seq_d;
  logic             wait_q, wait_d;
  logic [FB_AW-1:0] idx_q, idx_d;
  logic             cap_q, cap_d;
  logic [7:0]       data_q, data_d;
  logic [6:0]       vop_q, vop_d;
  logic             ref_pend_q, ref_pend_d;
  logic             con_pend_q, con_pend_d;

  logic       tx_vld, tx_rdy, tx_done, tx_dc, last_cmd, req_ok, cmd_state;
  logic [7:0] tx_dat;
  lcd_state_e cmd_next;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    init_cmd = CMD_FUNC_EXT;
      3'd1:    init_cmd = CMD_VOP | {1'b0, CONTRAST};
      3'd2:    init_cmd = CMD_TEMP | {6'd0, TEMP_COEF};
      3'd3:    init_cmd = CMD_BIAS | {5'd0, BIAS};
      3'd4:    init_cmd = CMD_FUNC_BASIC;
      default: init_cmd = CMD_DISP_NORMAL;
    endcase
  endfunction

`ifdef LCD_AUTO_REFRESH_EN
  localparam int ARW = $clog2(REFRESH_PERIOD_CLKS);
  logic [ARW-1:0] ar_cnt_q;
  logic           ar_tc;

  assign ar_tc = (ar_cnt_q == ARW'(REFRESH_PERIOD_CLKS - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)                         ar_cnt_q <= '0;
    else if (state_q == ST_DONE || ar_tc) ar_cnt_q <= '0;
    else                                  ar_cnt_q <= ar_cnt_q + 1'b1;
  end
`endif

  lcd_byte_sender #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_sender (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .tx_dat_i  (tx_dat),
    .tx_dc_i   (tx_dc),
    .tx_vld_i  (tx_vld),
    .tx_rdy_o  (tx_rdy),
    .tx_done_o (tx_done),
    .dc_o      (o_LCD_DC),
    .spi_clk_o (o_SPI_Clk),
    .spi_mosi_o(o_SPI_MOSI)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_RST_HOLD;
      hold_q     <= '0;
      seq_q      <= '0;
      wait_q     <= 1'b0;
      idx_q      <= '0;
      cap_q      <= 1'b0;
      data_q     <= '0;
      vop_q      <= CONTRAST;
      ref_pend_q <= 1'b0;
      con_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      seq_q      <= seq_d;
      wait_q     <= wait_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      data_q     <= data_d;
      vop_q      <= vop_d;
      ref_pend_q <= ref_pend_d;
      con_pend_q <= con_pend_d;
    end
  end

  assign req_ok    = !(state_q inside {ST_RST_HOLD, ST_RST_REL, ST_INIT});
  assign cmd_state = state_q inside {ST_INIT, ST_SETXY, ST_CONTRAST};

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    seq_d      = seq_q;
    wait_d     = wait_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    data_d     = data_q;
    vop_d      = vop_q;
    ref_pend_d = ref_pend_q;
    con_pend_d = con_pend_q;
    tx_vld     = 1'b0;
    tx_dat     = 8'h00;
    tx_dc      = 1'b0;
    last_cmd   = 1'b0;
    cmd_next   = ST_IDLE;

    case (state_q)
      ST_RST_HOLD: begin
        if (hold_q == HW'(RST_HOLD_CLKS - 1)) state_d = ST_RST_REL;
        else                                  hold_d  = hold_q + 1'b1;
      end
      ST_RST_REL: begin
        state_d = ST_INIT;
        seq_d   = '0;
      end
      ST_INIT: begin
        tx_vld   = !wait_q;
        tx_dat   = init_cmd(seq_q);
        last_cmd = (seq_q == 3'd5);
      end
      ST_IDLE: begin
        if (con_pend_q) begin
          state_d    = ST_CONTRAST;
          con_pend_d = 1'b0;
          seq_d      = '0;
        end else if (ref_pend_q) begin
          state_d    = ST_SETXY;
          ref_pend_d = 1'b0;
          seq_d      = '0;
          idx_d      = '0;
        end
      end
      ST_SETXY: begin
        tx_vld   = !wait_q;
        tx_dat   = (seq_q == 3'd0) ? CMD_SET_X : CMD_SET_Y;
        last_cmd = (seq_q == 3'd1);
        cmd_next = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_SEND;
        cap_d   = 1'b0;
      end
      ST_SEND: begin
        // Read data is only guaranteed in the first SEND cycle, so hold a copy.
        tx_vld = !wait_q;
        tx_dc  = 1'b1;
        tx_dat = cap_q ? data_q : i_Fb_Data;
        if (!cap_q) begin
          cap_d  = 1'b1;
          data_d = i_Fb_Data;
        end
        if (tx_done) begin
          if (idx_q == FB_AW'(FB_BYTES - 1)) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            state_d = ST_FETCH;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_CONTRAST: begin
        tx_vld   = !wait_q;
        last_cmd = (seq_q == 3'd2);
        case (seq_q)
          3'd0:    tx_dat = CMD_FUNC_EXT;
          3'd1:    tx_dat = CMD_VOP | {1'b0, vop_q};
          default: tx_dat = CMD_FUNC_BASIC;
        endcase
      end
      default: state_d = ST_RST_HOLD;
    endcase

    if (tx_vld && tx_rdy) wait_d = 1'b1;
    if (tx_done)          wait_d = 1'b0;

    if (cmd_state && tx_done) begin
      if (last_cmd) state_d = cmd_next;
      else          seq_d   = seq_q + 3'd1;
    end

    // New requests win over the clear on leaving IDLE so none is lost.
    if (req_ok && i_Refresh) ref_pend_d = 1'b1;
    if (req_ok && i_Contrast_Wr) begin
      con_pend_d = 1'b1;
      vop_d      = i_Contrast;
    end
`ifdef LCD_AUTO_REFRESH_EN
    if (req_ok && ar_tc) ref_pend_d = 1'b1;
`endif
  end

  assign o_Fb_Addr    = idx_q;
  assign o_Fb_Rd      = (state_q == ST_FETCH);
  assign o_Busy       = (state_q != ST_IDLE);
  assign o_Frame_Done = (state_q == ST_DONE);
  assign o_LCD_RST    = (state_q != ST_RST_HOLD);
  assign o_LCD_CE     = !(state_q inside {ST_INIT, ST_SETXY, ST_FETCH, ST_SEND, ST_CONTRAST});

endmodule

// File: tb/tb_spi_lcd_frame_streamer.sv
// Scoreboard bench for spi_lcd_frame_streamer: expected {CE,DC,byte} queued on stimulus, popped per SPI byte.
`timescale 1ns/1ps
module tb_spi_lcd_frame_streamer;

  localparam int FB_BYTES = 504;
  localparam int FB_AW    = 9;
  localparam int P_AUTO   = 5000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             refresh = 1'b0;
  logic             con_wr = 1'b0;
  logic [6:0]       con = 7'h00;
  logic [FB_AW-1:0] fb_addr;
  logic             fb_rd;
  logic [7:0]       fb_data = 8'h00;
  logic             busy, frame_done, sclk, mosi, lcd_dc, lcd_rst, lcd_ce;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int data_bytes = 0;
  int bad_addr = 0;
  int rd_cnt[512];
  logic [9:0] exp_q[$];

  spi_lcd_frame_streamer #(
    .CLKS_PER_HALF_BIT(2),
    .RST_HOLD_CLKS    (16)
`ifdef LCD_AUTO_REFRESH_EN
    , .REFRESH_PERIOD_CLKS(P_AUTO)
`endif
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Refresh    (refresh),
    .i_Contrast_Wr(con_wr),
    .i_Contrast   (con),
    .o_Fb_Addr    (fb_addr),
    .o_Fb_Rd      (fb_rd),
    .i_Fb_Data    (fb_data),
    .o_Busy       (busy),
    .o_Frame_Done (frame_done),
    .o_SPI_Clk    (sclk),
    .o_SPI_MOSI   (mosi),
    .o_LCD_DC     (lcd_dc),
    .o_LCD_RST    (lcd_rst),
    .o_LCD_CE     (lcd_ce)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Framebuffer byte n holds n[7:0]; data appears the cycle after the read strobe.
  always @(posedge clk) if (fb_rd) fb_data <= fb_addr[7:0];

  always @(negedge clk) begin
    if (fb_rd) begin
      if (fb_addr >= FB_AW'(FB_BYTES)) bad_addr++;
      else rd_cnt[fb_addr]++;
    end
    if (frame_done) done_cnt++;
  end

  int         bitn = 0;
  logic [7:0] sh = 8'h00;
  logic [9:0] got;
  logic [31:0] want;
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bitn = 0;
    end else begin
      #1;
      sh = {sh[6:0], mosi};
      bitn++;
      if (bitn == 8) begin
        bitn = 0;
        got  = {lcd_ce, lcd_dc, sh};
        if (lcd_dc) data_bytes++;
        want = (exp_q.size() > 0) ? {22'd0, exp_q.pop_front()} : 32'hDEAD;
        check_eq("spi_byte", {22'd0, got}, want);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic [7:0] b);
    exp_q.push_back({2'b00, b});
  endtask

  task automatic push_init();
    push_cmd(8'h21); push_cmd(8'hB1); push_cmd(8'h04);
    push_cmd(8'h14); push_cmd(8'h20); push_cmd(8'h0C);
  endtask

  task automatic push_frame();
    logic [7:0] b;
    push_cmd(8'h80);
    push_cmd(8'h40);
    for (int n = 0; n < FB_BYTES; n++) begin
      b = 8'(n);
      exp_q.push_back({2'b01, b});
    end
  endtask

  task automatic pulse_refresh();
    @(negedge clk) refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_in_time"}, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_data(input int target, input int budget);
    int n = 0;
    while (data_bytes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("data_progress", (data_bytes >= target) ? 1 : 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rst"},   lcd_rst, 0);
    check_eq({tag, "_ce"},    lcd_ce, 1);
    check_eq({tag, "_dc"},    lcd_dc, 0);
    check_eq({tag, "_busy"},  busy, 1);
    check_eq({tag, "_done"},  frame_done, 0);
    check_eq({tag, "_addr"},  fb_addr, 0);
    check_eq({tag, "_rd"},    fb_rd, 0);
    check_eq({tag, "_sclk"},  sclk, 0);
  endtask

  task automatic release_and_measure();
    int n = 0;
    @(negedge clk) rst_n = 1'b1;
    while (!lcd_rst && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check_eq("rst_low_cycles", n, 16);
  endtask

  task automatic check_reads(input string tag, input int times);
    int bad = 0;
    for (int a = 0; a < FB_BYTES; a++) if (rd_cnt[a] != times) bad++;
    check_eq({tag, "_reads"}, bad, 0);
    check_eq({tag, "_bad_addr"}, bad_addr, 0);
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    push_init();
    release_and_measure();
    wait_drained("init", 3000);
    check_eq("init_busy", busy, 0);
    check_eq("init_ce", lcd_ce, 1);

`ifdef LCD_AUTO_REFRESH_EN
    push_frame();
    push_frame();
    n = 0;
    while (done_cnt < 1 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check_eq("auto_first_done", (done_cnt >= 1) ? 1 : 0, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < P_AUTO + 100);
    check_eq("auto_gap", (n >= P_AUTO && n <= P_AUTO + 4) ? P_AUTO : n, P_AUTO);
    wait_drained("auto_frame", 40000);
    check_eq("auto_done_cnt", done_cnt, 2);
`else
    push_frame();
    pulse_refresh();
    wait_drained("frame1", 30000);
    check_eq("frame1_done_cnt", done_cnt, 1);
    check_eq("frame1_ce", lcd_ce, 1);
    check_reads("frame1", 1);

    // Contrast and refresh together, then three refreshes during the frame.
    push_cmd(8'h21); push_cmd(8'hC5); push_cmd(8'h20);
    push_frame();
    push_frame();
    @(negedge clk);
    con = 7'h45; con_wr = 1'b1; refresh = 1'b1;
    @(negedge clk);
    con_wr = 1'b0; refresh = 1'b0;
    wait_data(FB_BYTES + 100, 20000);
    for (int k = 0; k < 3; k++) begin
      pulse_refresh();
      repeat (50) @(negedge clk);
    end
    wait_drained("frames23", 60000);
    repeat (300) @(negedge clk);
    check_eq("frames23_done_cnt", done_cnt, 3);
    check_eq("frames23_idle", busy, 0);
    check_reads("frames23", 3);

    // Reset in the middle of a frame.
    push_frame();
    pulse_refresh();
    wait_data(3 * FB_BYTES + 200, 20000);
    d0 = done_cnt;
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (5) @(negedge clk);
    push_init();
    release_and_measure();
    wait_drained("reinit", 3000);
    repeat (100) @(negedge clk);
    check_eq("reinit_no_done", done_cnt, d0);
    check_eq("reinit_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
